// File: rtl/right_shift_rot_32_if.sv
// right_shift_rot_32_if: operand/amount/mode bus and registered result of the shift/rotate unit (arith exists only with RSR_ARITH_EN).
interface right_shift_rot_32_if;
  logic [31:0] in_i;
  logic        rotate_i;
  logic [4:0]  select_i;
  logic [31:0] out_o;
`ifdef RSR_ARITH_EN
  logic        arith_i;
  modport master (output in_i, rotate_i, select_i, arith_i, input out_o);
  modport slave (input in_i, rotate_i, select_i, arith_i, output out_o);
`else
  modport master (output in_i, rotate_i, select_i, input out_o);
  modport slave (input in_i, rotate_i, select_i, output out_o);
`endif
endinterface

// File: rtl/right_shift_rot_32.sv
// right_shift_rot_32: registered 32-bit logical shift right / rotate right barrel unit; RSR_ARITH_EN adds arithmetic shift.
module right_shift_rot_32 (
  input  logic                   clk,
  input  logic                   reset,
  right_shift_rot_32_if.slave    bus
);
  logic        fill;
  logic [31:0] s1, s2, s3, s4, out_d, out_q;
`ifdef RSR_ARITH_EN
  assign fill = ~bus.rotate_i & bus.arith_i & bus.in_i[31];
`else
  assign fill = 1'b0;
`endif
  always_comb begin
    s1    = bus.select_i[0] ? {bus.rotate_i ? bus.in_i[0] : fill, bus.in_i[31:1]} : bus.in_i;
    s2    = bus.select_i[1] ? {bus.rotate_i ? s1[1:0]  : {2{fill}},  s1[31:2]}  : s1;
    s3    = bus.select_i[2] ? {bus.rotate_i ? s2[3:0]  : {4{fill}},  s2[31:4]}  : s2;
    s4    = bus.select_i[3] ? {bus.rotate_i ? s3[7:0]  : {8{fill}},  s3[31:8]}  : s3;
    out_d = bus.select_i[4] ? {bus.rotate_i ? s4[15:0] : {16{fill}}, s4[31:16]} : s4;
  end
  always_ff @(posedge clk)
    out_q <= reset ? 32'h0 : out_d;
  assign bus.out_o = out_q;
endmodule

// File: tb/tb_right_shift_rot_32.sv
// tb_right_shift_rot_32: directed self-checking bench for right_shift_rot_32.
module tb_right_shift_rot_32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  right_shift_rot_32_if bus ();
  right_shift_rot_32 dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic apply(input logic [31:0] d, input logic rot, input logic [4:0] sel, input logic ar);
    bus.in_i = d;
    bus.rotate_i = rot;
    bus.select_i = sel;
`ifdef RSR_ARITH_EN
    bus.arith_i = ar;
`else
    if (ar) $display("note: arith ignored in this build");
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      apply(32'hFFFFFFFF, 1'b0, 5'd0, 1'b0);
      total++;
      if (bus.out_o !== 32'h0) begin
        bad++;
        $display("FAIL reset_edge%0d got=%h exp=%h", i, bus.out_o, 32'h0);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_shift();
    logic [31:0] vin [4] = '{32'hF0000001, 32'h80000000, 32'hDEADBEEF, 32'hFFFFFFFF};
    logic [4:0]  vsel [4] = '{5'd25, 5'd31, 5'd16, 5'd1};
    logic [31:0] vexp [4] = '{32'h00000078, 32'h00000001, 32'h0000DEAD, 32'h7FFFFFFF};
    for (int i = 0; i < 4; i++) begin
      apply(vin[i], 1'b0, vsel[i], 1'b0);
      total++;
      if (bus.out_o !== vexp[i]) begin
        bad++;
        $display("FAIL shift%0d got=%h exp=%h", i, bus.out_o, vexp[i]);
      end
    end
  endtask

  task automatic test_rotate();
    logic [31:0] vin [4] = '{32'h00000001, 32'h00000001, 32'hDEADBEEF, 32'h12345678};
    logic [4:0]  vsel [4] = '{5'd1, 5'd31, 5'd16, 5'd4};
    logic [31:0] vexp [4] = '{32'h80000000, 32'h00000002, 32'hBEEFDEAD, 32'h81234567};
    for (int i = 0; i < 4; i++) begin
      apply(vin[i], 1'b1, vsel[i], 1'b0);
      total++;
      if (bus.out_o !== vexp[i]) begin
        bad++;
        $display("FAIL rotate%0d got=%h exp=%h", i, bus.out_o, vexp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vin [3] = '{32'h0000001F, 32'h0000007F, 32'h0000007F};
    logic        vrot [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] vexp [3] = '{32'hF8000000, 32'h00000003, 32'hF8000003};
    for (int i = 0; i < 3; i++) begin
      apply(vin[i], vrot[i], 5'd5, 1'b0);
      total++;
      if (bus.out_o !== vexp[i]) begin
        bad++;
        $display("FAIL b2b%0d got=%h exp=%h", i, bus.out_o, vexp[i]);
      end
    end
    #3;
    total++;
    if (bus.out_o !== 32'hF8000003) begin
      bad++;
      $display("FAIL hold got=%h exp=%h", bus.out_o, 32'hF8000003);
    end
  endtask

  task automatic test_pass();
    for (int r = 0; r < 2; r++) begin
      apply(32'hA5A5A5A5, r[0], 5'd0, 1'b0);
      total++;
      if (bus.out_o !== 32'hA5A5A5A5) begin
        bad++;
        $display("FAIL pass_rot%0d got=%h exp=%h", r, bus.out_o, 32'hA5A5A5A5);
      end
    end
  endtask

  task automatic test_midstream_reset();
    reset = 1'b1;
    apply(32'hFFFF0000, 1'b0, 5'd4, 1'b0);
    total++;
    if (bus.out_o !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset got=%h exp=%h", bus.out_o, 32'h0);
    end
    reset = 1'b0;
    apply(32'hFFFF0000, 1'b0, 5'd4, 1'b0);
    total++;
    if (bus.out_o !== 32'h0FFFF000) begin
      bad++;
      $display("FAIL after_reset got=%h exp=%h", bus.out_o, 32'h0FFFF000);
    end
  endtask

`ifdef RSR_ARITH_EN
  task automatic test_arith();
    logic [31:0] vin [4] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
    logic        vrot [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic        var_ [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [4:0]  vsel [4] = '{5'd4, 5'd4, 5'd31, 5'd4};
    logic [31:0] vexp [4] = '{32'hF8000000, 32'h08000000, 32'hFFFFFFFF, 32'h08000000};
    for (int i = 0; i < 4; i++) begin
      apply(vin[i], vrot[i], vsel[i], var_[i]);
      total++;
      if (bus.out_o !== vexp[i]) begin
        bad++;
        $display("FAIL arith%0d got=%h exp=%h", i, bus.out_o, vexp[i]);
      end
    end
  endtask
`endif

  initial begin
    bus.in_i = 32'h0;
    bus.rotate_i = 1'b0;
    bus.select_i = 5'd0;
`ifdef RSR_ARITH_EN
    bus.arith_i = 1'b0;
`endif
    test_reset();
    test_shift();
    test_rotate();
    test_back_to_back();
    test_pass();
    test_midstream_reset();
`ifdef RSR_ARITH_EN
    test_arith();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
